alu_muldiv_sequencer: RTL and testbench
=======================================

# alu_muldiv_sequencer

Multi-cycle sequencer for the ALU's MUL (sel 4'b0011) and DIV (sel 4'b0100) operations. It accepts one operation at a time from the execute stage, runs an iterative shift-add multiply or restoring divide over WIDTH cycles, and returns a double-width result. While it works it asserts a stall to the pipeline. All single-cycle ALU codes (AND, OR, ADD, SUB, SLT, NOP) bypass this block and are ignored by it.

## Interface
- WIDTH, 32, operand width in bits; must be at least 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe, sampled on the rising edge of clk.
- sel  in  4  ALU select code from the ALU control decoder; only 4'b0011 and 4'b0100 are acted on.
- a  in  WIDTH  multiplicand or dividend, unsigned.
- b  in  WIDTH  multiplier or divisor, unsigned.
- busy  out  1  an iteration is in progress.
- done  out  1  one-cycle pulse; result outputs are valid.
- result_hi  out  WIDTH  MUL: product[2*WIDTH-1:WIDTH]. DIV: remainder.
- result_lo  out  WIDTH  MUL: product[WIDTH-1:0]. DIV: quotient.
- div_by_zero  out  1  set with done when DIV had b==0. Held until the next accepted start.
- stall  out  1  combinational: busy | (start & accept_ok & sel_is_muldiv).

## Operation
- States: IDLE, RUN, DONE.
- accept_ok is true in IDLE or DONE. A start with sel of MUL or DIV is accepted there.
- Starts in RUN are ignored; the pipeline must hold the request and retry.
- Starts with any other sel are ignored in every state.
- On accept:
  - latch a, b, and the op;
  - clear the iteration counter;
  - clear div_by_zero;
  - go to RUN.
- DIV with b==0 is the exception: go directly to DONE with result_lo = all ones, result_hi = a, div_by_zero = 1.
- MUL: unsigned shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
- DIV: unsigned restoring division, one quotient bit per cycle, MSB first. The remainder register is WIDTH+1 bits, which keeps the subtract from overflowing.
- RUN to DONE after exactly WIDTH iterations. DONE to IDLE after one cycle, unless a new start is accepted in that same cycle.
- result_hi, result_lo, and div_by_zero hold their values from DONE until the next accepted start. They are not updated while in RUN.
- Reset (any time, including mid-RUN):
  - state goes to IDLE and busy, done, div_by_zero, result_hi, and result_lo go to 0;
  - the counter and internal registers are cleared;
  - an operation in flight is discarded and never reported.

## Timing
- Accept at edge E0. busy is high after edges E0 through E(WIDTH-1), which is WIDTH cycles.
- done is high for the single cycle after edge E(WIDTH), with busy low. Total latency is WIDTH+1 cycles from accept to done.
- Divide by zero: done is high the cycle after E0, busy never rises, and latency is 1.
- stall rises in the same cycle as the accepted start (combinational). It falls in the cycle where done is asserted, so the stalled instruction captures the result on that edge.
- Back-to-back: a start accepted in the DONE cycle begins a new RUN on that edge. done then drops the next cycle.
- All outputs except stall are registered.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit sel constants: SEL_AND 0000, SEL_OR 0001, SEL_ADD 0010, SEL_MUL 0011, SEL_DIV 0100, SEL_SUB 0110, SEL_SLT 0111, SEL_NOP 1000;
  - the state enum for this block.
- One sub-module, muldiv_step, is a combinational single-iteration step shared by both ops. Its inputs are the op, the accumulator or remainder, and the operand. Its outputs are the next accumulator or remainder and the quotient bit.
- The FSM, counter, and output registers stay in the top module.

## Test plan
- MUL, a=7, b=6: done at cycle WIDTH+1 with result_lo=42, result_hi=0, and busy high for exactly 32 cycles.
- MUL, a=b=0xFFFFFFFF: result_hi=0xFFFFFFFE, result_lo=0x00000001.
- DIV, a=100, b=7: result_lo=14, result_hi=2, div_by_zero=0. Then DIV with a=5, b=0: done one cycle after accept, result_lo=0xFFFFFFFF, result_hi=5, div_by_zero=1.
- start with sel=ADD (0010) while idle: no busy, no done, stall=0. start with MUL at RUN cycle 10 of a DIV: ignored, and the DIV result is unchanged.
- Assert rst_n low at RUN cycle 15, release, then issue MUL a=3, b=4: all outputs 0 during reset, no spurious done, then result_lo=12.
- Back-to-back: a second MUL (a=2, b=9) is accepted in the DONE cycle of the first. done pulses twice, WIDTH+1 cycles apart, and the second result_lo=18.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes and the
// multi-cycle mul/div sequencer state and op types.
package alu_pkg;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_MUL = 4'b0011;
  localparam logic [3:0] SEL_DIV = 4'b0100;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOP = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic {
    OP_MUL,
    OP_DIV
  } op_e;

  function automatic logic is_muldiv(logic [3:0] sel);
    return (sel == SEL_MUL) || (sel == SEL_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_sequencer_if.sv
// Request/response bundle between the execute
// stage and the mul/div sequencer.
interface alu_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;
  logic             stall;

  modport master (
    output start, sel, a, b,
    input  busy, done, result_hi, result_lo,
    input  div_by_zero, stall
  );

  modport slave (
    input  start, sel, a, b,
    output busy, done, result_hi, result_lo,
    output div_by_zero, stall
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or
// restoring divide on a shared 2*WIDTH+1 register.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] opnd,
  output logic [2*WIDTH:0] acc_o,
  output logic             q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   rem_n;

  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
          + (acc_i[0] ? {1'b0, opnd} : '0);
    // DIV: remainder in [2W:W], dividend bits
    // shift out of [W-1:0] MSB first.
    r_sh  = {acc_i[2*WIDTH:WIDTH], acc_i[WIDTH-1]};
    diff  = r_sh - {2'b00, opnd};
    rem_n = diff[WIDTH+1] ? r_sh[WIDTH:0]
                          : diff[WIDTH:0];
    acc_o = '0;
    q_bit = 1'b0;
    if (op == OP_MUL) begin
      acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
    end else begin
      q_bit = ~diff[WIDTH+1];
      acc_o = {rem_n, acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MUL/DIV sequencer: accepts one op,
// iterates WIDTH cycles, stalls the pipeline meanwhile.
module alu_muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  alu_muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [2*WIDTH:0] step_acc;
  logic [2*WIDTH:0] step_nxt;
  logic             q_bit;
  logic             accept;
  logic             is_div;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .acc_i (acc_q),
    .opnd  (opnd_q),
    .acc_o (step_acc),
    .q_bit (q_bit)
  );

  assign step_nxt = step_acc
                  | {{(2*WIDTH){1'b0}}, q_bit};
  assign is_div   = (bus.sel == SEL_DIV);
  assign accept   = bus.start
                  & (state_q != ST_RUN)
                  & is_muldiv(bus.sel);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_RUN: begin
        acc_d  = step_nxt;
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = step_nxt[2*WIDTH-1:WIDTH];
          lo_d    = step_nxt[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      op_d  = is_div ? OP_DIV : OP_MUL;
      cnt_d = '0;
      dbz_d = 1'b0;
      if (is_div && (bus.b == '0)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        dbz_d   = 1'b1;
        hi_d    = bus.a;
        lo_d    = '1;
      end else begin
        state_d = ST_RUN;
        busy_d  = 1'b1;
        // MUL keeps the multiplier in the low half;
        // DIV keeps the dividend there.
        opnd_d  = is_div ? bus.b : bus.a;
        acc_d   = {{(WIDTH+1){1'b0}},
                   is_div ? bus.a : bus.b};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.result_hi   = hi_q;
  assign bus.result_lo   = lo_q;
  assign bus.stall       = busy_q | accept;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer: directed cases
// plus random traffic against an arithmetic model.
module tb_alu_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [3:0] MUL = 4'b0011;
  localparam logic [3:0] DIV = 4'b0100;
  localparam logic [3:0] ADD = 4'b0010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_sequencer_if #(.WIDTH(W)) bus();

  alu_muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               name, got, exp);
    end
  endtask

  function automatic logic md(logic [3:0] s);
    return (s == MUL) || (s == DIV);
  endfunction

  // Model: cycles left until done, plus results
  // computed directly with * / %.
  int         m_left;
  logic       m_done, m_dbz;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_hi   <= p_hi;
          m_lo   <= p_lo;
        end
      end else if (bus.start && md(bus.sel)) begin
        m_dbz <= 1'b0;
        if (bus.sel == DIV && bus.b == 0) begin
          m_done <= 1'b1;
          m_dbz  <= 1'b1;
          m_hi   <= bus.a;
          m_lo   <= '1;
        end else begin
          m_left <= W;
          if (bus.sel == MUL)
            {p_hi, p_lo} <= 64'(bus.a) * 64'(bus.b);
          else begin
            p_hi <= bus.a % bus.b;
            p_lo <= bus.a / bus.b;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", bus.busy, m_left > 0);
    chk("done", bus.done, m_done);
    chk("stall", bus.stall, (m_left > 0) ||
        (bus.start && m_left == 0 && md(bus.sel)));
    chk("hi", bus.result_hi, m_hi);
    chk("lo", bus.result_lo, m_lo);
    chk("dbz", bus.div_by_zero, m_dbz);
  end

  task automatic op(logic [3:0] s, logic [W-1:0] x,
                    logic [W-1:0] y);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.sel   = s;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat,
                           output int bn);
    bit seen = 1'b0;
    lat = 0;
    bn  = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bn++;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", bus.done, 1);
  endtask

  int lat, bn, r;

  initial begin
    bus.start = 1'b0;
    bus.sel   = 4'b0000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_lo", bus.result_lo, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    op(MUL, 7, 6);
    wait_done(lat, bn);
    chk("mul7x6_lat", lat, W + 1);
    chk("mul7x6_busy", bn, W);
    chk("mul7x6_lo", bus.result_lo, 42);
    chk("mul7x6_hi", bus.result_hi, 0);

    op(MUL, '1, '1);
    wait_done(lat, bn);
    chk("mulmax_hi", bus.result_hi, 32'hFFFFFFFE);
    chk("mulmax_lo", bus.result_lo, 32'h00000001);

    op(DIV, 100, 7);
    wait_done(lat, bn);
    chk("div100_lo", bus.result_lo, 14);
    chk("div100_hi", bus.result_hi, 2);
    chk("div100_dbz", bus.div_by_zero, 0);

    op(DIV, 5, 0);
    wait_done(lat, bn);
    chk("dz_lat", lat, 1);
    chk("dz_busy", bn, 0);
    chk("dz_lo", bus.result_lo, 32'hFFFFFFFF);
    chk("dz_hi", bus.result_hi, 5);
    chk("dz_flag", bus.div_by_zero, 1);

    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.sel   = ADD;
    @(negedge clk);
    chk("add_stall", bus.stall, 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("add_busy", bus.busy, 0);
    chk("add_done", bus.done, 0);

    op(DIV, 1000, 3);
    repeat (10) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.sel   = MUL;
    bus.a     = 9;
    bus.b     = 9;
    @(negedge clk);
    chk("run_stall", bus.stall, 1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, bn);
    chk("ign_lo", bus.result_lo, 333);
    chk("ign_hi", bus.result_hi, 1);

    op(MUL, 123, 456);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_hi", bus.result_hi, 0);
    chk("mr_lo", bus.result_lo, 0);
    chk("mr_dbz", bus.div_by_zero, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    op(MUL, 3, 4);
    wait_done(lat, bn);
    chk("mr_mul_lat", lat, W + 1);
    chk("mr_mul_lo", bus.result_lo, 12);

    op(MUL, 5, 5);
    repeat (W) @(posedge clk);
    #1;
    chk("b2b_done1", bus.done, 1);
    chk("b2b_lo1", bus.result_lo, 25);
    bus.start = 1'b1;
    bus.sel   = MUL;
    bus.a     = 2;
    bus.b     = 9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("b2b_drop", bus.done, 0);
    wait_done(lat, bn);
    chk("b2b_lat", lat, W + 1);
    chk("b2b_lo2", bus.result_lo, 18);

    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      bus.start = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: bus.sel = MUL;
        3, 4, 5: bus.sel = DIV;
        6:       bus.sel = ADD;
        7:       bus.sel = 4'b0110;
        8:       bus.sel = 4'b1000;
        default: bus.sel = 4'($urandom);
      endcase
      bus.a = ($urandom_range(0, 4) == 0) ? '1
                                          : $urandom;
      case ($urandom_range(0, 3))
        0:       bus.b = '0;
        1:       bus.b = W'($urandom_range(1, 15));
        2:       bus.b = $urandom;
        default: bus.b = '1;
      endcase
    end
    #1 bus.start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
